jesd204_rx_pattern_checker: RTL and testbench

- Sits directly downstream of the jesd204_rx link layer and consumes rx_data/rx_valid/sync.
- Checks every received beat against the deterministic counter pattern driven into the transmit side in loopback and hardware bring-up.
- Reports lock, sticky mismatch, a saturating error count and the first failing lane.
- Used by loopback benches and on-chip bring-up in place of ad-hoc comparison logic.

---
 rtl/jesd204_rx_pattern_checker.sv | 203 ++++++++++++++++++++
 tb/tb_jesd204_rx_pattern_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_rx_pattern_checker.sv
// Checks JESD204 RX beats against the counter pattern (octet = {beat, octet index}) and reports lock/error status.
// Optional macro JESD204_RX_PATTERN_CHECKER_LATENCY_EN adds status_sync_latency (cycles from sync rise to first valid).
module jesd204_rx_pattern_checker #(
   parameter int NUM_LANES       = 4,
   parameter int NUM_LINKS       = 1,
   parameter int DATA_PATH_WIDTH = 4,
   parameter int SCRAMBLER_MASK  = 1,
   parameter int LOCK_BEATS      = 16,
   parameter int ERR_CNT_WIDTH   = 16
) (
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic [NUM_LINKS-1:0]                   sync,
   input  logic                                   rx_valid,
   input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] rx_data,
   input  logic                                   ctrl_clear,
   output logic                                   status_locked,
   output logic                                   status_mismatch,
   output logic [ERR_CNT_WIDTH-1:0]               status_err_cnt,
   output logic [7:0]                             status_first_err_lane,
   output logic [1:0]                             status_state
`ifdef JESD204_RX_PATTERN_CHECKER_LATENCY_EN
   ,
   output logic [15:0]                            status_sync_latency
`endif
);

   localparam int DPW      = DATA_PATH_WIDTH;
   localparam int DPW_LOG2 = (DPW == 8) ? 3 : (DPW == 4) ? 2 : 1;
   localparam int BEAT_W   = 8 - DPW_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_CHECK  = 2'd2,
      ST_UNUSED = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic                     sync_ok;
   logic                     sample;
   logic                     first_beat;
   logic [NUM_LANES-1:0]     lane_fail_d, lane_fail_q;
   logic                     cmp_vld_q;
   logic                     res_match, res_mismatch;
   logic [7:0]               fail_lane;
   logic [7:0]               lock_q, lock_d;
   logic                     mismatch_q, mismatch_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
   logic [7:0]               first_q, first_d;

   assign sync_ok = &sync;

   // NOTE: every variable assigned in an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      sample     = 1'b0;
      first_beat = 1'b0;
      if (!sync_ok) begin
         state_d = ST_IDLE;
         beat_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
               beat_d  = '0;
            end
            ST_ARMED: begin
               if (rx_valid) begin
                  sample     = 1'b1;
                  first_beat = 1'b1;
                  state_d    = ST_CHECK;
                  beat_d     = beat_q + BEAT_W'(1);
               end
            end
            ST_CHECK: begin
               if (rx_valid) begin
                  sample = 1'b1;
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               beat_d  = '0;
            end
         endcase
      end
   end

   // Scrambler start-up garbage lands in octets 0 and 1 of the first beat only.
   always_comb begin
      lane_fail_d = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         for (int k = 0; k < DPW; k++) begin
            if (!(first_beat && (SCRAMBLER_MASK != 0) && (k < 2)) &&
                (rx_data[(l*DPW+k)*8 +: 8] != {beat_q, k[DPW_LOG2-1:0]})) begin
               lane_fail_d[l] = 1'b1;
            end
         end
      end
   end

   assign res_match    = cmp_vld_q && !(|lane_fail_q);
   assign res_mismatch = cmp_vld_q &&  (|lane_fail_q);

   // Walk downwards so the lowest failing lane is the one left in fail_lane.
   always_comb begin
      fail_lane = 8'hff;
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
         if (lane_fail_q[l]) fail_lane = 8'(l);
      end
   end

   always_comb begin
      lock_d = lock_q;
      if (!sync_ok || res_mismatch) begin
         lock_d = '0;
      end else if (res_match && (lock_q != 8'(LOCK_BEATS))) begin
         lock_d = lock_q + 8'd1;
      end
   end

   // Clear is applied first so a mismatch arriving on the same edge still registers.
   always_comb begin
      mismatch_d = mismatch_q;
      err_d      = err_q;
      first_d    = first_q;
      if (ctrl_clear) begin
         mismatch_d = 1'b0;
         err_d      = '0;
         first_d    = 8'hff;
      end
      if (res_mismatch) begin
         mismatch_d = 1'b1;
         if (err_d != '1) err_d = err_d + ERR_CNT_WIDTH'(1);
         if (first_d == 8'hff) first_d = fail_lane;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         cmp_vld_q   <= 1'b0;
         lane_fail_q <= '0;
         lock_q      <= '0;
         mismatch_q  <= 1'b0;
         err_q       <= '0;
         first_q     <= 8'hff;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         cmp_vld_q   <= sample;
         lane_fail_q <= sample ? lane_fail_d : '0;
         lock_q      <= lock_d;
         mismatch_q  <= mismatch_d;
         err_q       <= err_d;
         first_q     <= first_d;
      end
   end

   assign status_locked         = (lock_q == 8'(LOCK_BEATS));
   assign status_mismatch       = mismatch_q;
   assign status_err_cnt        = err_q;
   assign status_first_err_lane = first_q;
   assign status_state          = state_q;

`ifdef JESD204_RX_PATTERN_CHECKER_LATENCY_EN
   logic [15:0] lat_cnt_q, lat_cnt_d;
   logic [15:0] lat_q, lat_d;
   logic [15:0] lat_inc;

   assign lat_inc = (lat_cnt_q == 16'hffff) ? lat_cnt_q : lat_cnt_q + 16'd1;

   // The rise edge itself counts as zero; the edge taking the first valid beat closes the count.
   always_comb begin
      lat_cnt_d = lat_cnt_q;
      lat_d     = lat_q;
      if (sync_ok && (state_q == ST_IDLE)) begin
         lat_cnt_d = '0;
      end else if (sync_ok && (state_q == ST_ARMED)) begin
         if (rx_valid) lat_d     = lat_inc;
         else          lat_cnt_d = lat_inc;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lat_cnt_q <= '0;
         lat_q     <= '0;
      end else begin
         lat_cnt_q <= lat_cnt_d;
         lat_q     <= lat_d;
      end
   end

   assign status_sync_latency = lat_q;
`endif

endmodule

// File: tb/tb_jesd204_rx_pattern_checker.sv
// Scoreboard bench for jesd204_rx_pattern_checker: beat verdicts are queued when driven and retired one edge later.
module tb_jesd204_rx_pattern_checker;
   localparam int NL  = 4;
   localparam int DPW = 4;
   localparam int LB  = 16;
   localparam int EW  = 16;
   localparam int DW  = NL * DPW * 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic [0:0]    sync_s;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          ctrl_clear;
   logic          status_locked;
   logic          status_mismatch;
   logic [EW-1:0] status_err_cnt;
   logic [7:0]    status_first_err_lane;
   logic [1:0]    status_state;
`ifdef JESD204_RX_PATTERN_CHECKER_LATENCY_EN
   logic [15:0]   status_sync_latency;
`endif

   jesd204_rx_pattern_checker #(
      .NUM_LANES(NL), .NUM_LINKS(1), .DATA_PATH_WIDTH(DPW),
      .SCRAMBLER_MASK(1), .LOCK_BEATS(LB), .ERR_CNT_WIDTH(EW)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .sync(sync_s),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .ctrl_clear(ctrl_clear),
      .status_locked(status_locked),
      .status_mismatch(status_mismatch),
      .status_err_cnt(status_err_cnt),
      .status_first_err_lane(status_first_err_lane),
      .status_state(status_state)
`ifdef JESD204_RX_PATTERN_CHECKER_LATENCY_EN
      ,
      .status_sync_latency(status_sync_latency)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ok;
      int lane;
   } res_t;

   res_t res_q[$];
   int   m_state, m_beat, m_lock, m_err, m_first;
   bit   m_mm;
   int   n_pass, n_checks;
   int   tx_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [DW-1:0] pattern(input int b);
      logic [DW-1:0] d;
      d = '0;
      for (int l = 0; l < NL; l++)
         for (int k = 0; k < DPW; k++)
            d[(l*DPW+k)*8 +: 8] = 8'((b * DPW + k) % 256);
      return d;
   endfunction

   function automatic res_t judge(input logic [DW-1:0] d, input int b, input bit masked);
      res_t r;
      r.ok   = 1'b1;
      r.lane = 255;
      for (int l = NL - 1; l >= 0; l--)
         for (int k = 0; k < DPW; k++)
            if (!(masked && k < 2) && d[(l*DPW+k)*8 +: 8] != 8'((b * DPW + k) % 256)) begin
               r.ok   = 1'b0;
               r.lane = l;
            end
      return r;
   endfunction

   task automatic model_reset();
      m_state = 0; m_beat = 0; m_lock = 0; m_err = 0; m_first = 255; m_mm = 1'b0;
      res_q.delete();
   endtask

   // One clock: drive inputs, advance the model across the coming edge, then compare after the edge.
   task automatic cycle(input bit s, input bit v, input logic [DW-1:0] d, input bit clr, input bit chk);
      res_t r;
      bit   have;
      sync_s     = s;
      rx_valid   = v;
      rx_data    = d;
      ctrl_clear = clr;
      have = (res_q.size() != 0);
      if (have) r = res_q.pop_front();
      else      r = '{ok: 1'b1, lane: 255};
      if (!s) m_lock = 0;
      else if (have) m_lock = r.ok ? ((m_lock < LB) ? m_lock + 1 : LB) : 0;
      if (clr) begin m_mm = 1'b0; m_err = 0; m_first = 255; end
      if (have && !r.ok) begin
         m_mm = 1'b1;
         if (m_err < 65535) m_err++;
         if (m_first == 255) m_first = r.lane;
      end
      if (!s) begin
         m_state = 0; m_beat = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (v) begin
         res_q.push_back(judge(d, m_beat, m_state == 1));
         m_state = 2;
         m_beat  = (m_beat + 1) % (256 / DPW);
      end
      @(posedge clk);
      #1;
      if (chk) begin
         check("sb_locked", 32'(status_locked), 32'(m_lock == LB));
         check("sb_mismatch", 32'(status_mismatch), 32'(m_mm));
         check("sb_err_cnt", 32'(status_err_cnt), m_err);
         check("sb_first_lane", 32'(status_first_err_lane), m_first);
         check("sb_state", 32'(status_state), m_state);
      end
   endtask

   task automatic good(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, 1'b1, pattern(tx_b), 1'b0, 1'b1);
         tx_b++;
      end
   endtask

   logic [DW-1:0] d;

   initial begin
      n_pass = 0; n_checks = 0; tx_b = 0;
      resetn = 1'b0; sync_s = '0; rx_valid = 1'b0; rx_data = '0; ctrl_clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked", 32'(status_locked), 0);
      check("rst_mismatch", 32'(status_mismatch), 0);
      check("rst_err_cnt", 32'(status_err_cnt), 0);
      check("rst_first_lane", 32'(status_first_err_lane), 32'hff);
      check("rst_state", 32'(status_state), 0);
      resetn = 1'b1;
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Lock timing from the first valid beat
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      check("armed_state", 32'(status_state), 1);
      tx_b = 0;
      good(LB);
      check("lock_not_yet", 32'(status_locked), 0);
      good(1);
      check("lock_reached", 32'(status_locked), 1);
      check("lock_err_cnt", 32'(status_err_cnt), 0);
      check("lock_first_lane", 32'(status_first_err_lane), 32'hff);

      // Run through the 63 -> 0 beat counter wrap
      good(70 - tx_b);
      check("wrap_mismatch", 32'(status_mismatch), 0);
      check("wrap_locked", 32'(status_locked), 1);

      // Single corrupt octet (lane 2, octet 3)
      d = pattern(tx_b);
      d[(2*DPW+3)*8 +: 8] = d[(2*DPW+3)*8 +: 8] ^ 8'h01;
      cycle(1'b1, 1'b1, d, 1'b0, 1'b1);
      tx_b++;
      good(1);
      check("bad_mismatch", 32'(status_mismatch), 1);
      check("bad_err_cnt", 32'(status_err_cnt), 1);
      check("bad_first_lane", 32'(status_first_err_lane), 2);
      check("bad_locked", 32'(status_locked), 0);
      good(LB - 1);
      check("relock_not_yet", 32'(status_locked), 0);
      good(1);
      check("relock", 32'(status_locked), 1);

      // First-beat scrambler mask
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
      check("clr_err_cnt", 32'(status_err_cnt), 0);
      check("clr_first_lane", 32'(status_first_err_lane), 32'hff);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      for (int b = 0; b < 2; b++) begin
         d = pattern(b);
         for (int l = 0; l < NL; l++) begin
            d[(l*DPW+0)*8 +: 8] = 8'hA5;
            d[(l*DPW+1)*8 +: 8] = 8'h5A;
         end
         cycle(1'b1, 1'b1, d, 1'b0, 1'b1);
      end
      check("mask_first_ok", 32'(status_mismatch), 0);
      tx_b = 2;
      good(1);
      check("mask_second_err", 32'(status_err_cnt), 1);
      check("mask_second_lane", 32'(status_first_err_lane), 0);

      // Sync drop for three cycles with rx_valid held high
      cycle(1'b1, 1'b1, pattern(tx_b), 1'b1, 1'b1);
      tx_b++;
      good(10);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, pattern(tx_b), 1'b0, 1'b1);
         tx_b++;
      end
      check("drop_state", 32'(status_state), 0);
      check("drop_locked", 32'(status_locked), 0);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      check("resync_state", 32'(status_state), 1);
      tx_b = 0;
      good(1);
      check("check_state", 32'(status_state), 2);
      good(20);
      check("resync_mismatch", 32'(status_mismatch), 0);
      check("resync_err_cnt", 32'(status_err_cnt), 0);

      // Error counter saturation, then clear together with a bad result
      for (int i = 0; i < 65536 + 5; i++) cycle(1'b1, 1'b1, '0, 1'b0, 1'b0);
      check("sat_err_cnt", 32'(status_err_cnt), 32'hffff);
      check("sat_mismatch", 32'(status_mismatch), 1);
      cycle(1'b1, 1'b1, '0, 1'b1, 1'b1);
      check("clr_bad_err_cnt", 32'(status_err_cnt), 1);
      check("clr_bad_mismatch", 32'(status_mismatch), 1);
      check("clr_bad_lane", 32'(status_first_err_lane), 0);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);

`ifdef JESD204_RX_PATTERN_CHECKER_LATENCY_EN
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      repeat (6) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, pattern(0), 1'b0, 1'b1);
      check("sync_latency", 32'(status_sync_latency), 7);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
`endif

      // Asynchronous reset in the middle of a cycle
      #3;
      resetn = 1'b0;
      #1;
      check("arst_locked", 32'(status_locked), 0);
      check("arst_mismatch", 32'(status_mismatch), 0);
      check("arst_err_cnt", 32'(status_err_cnt), 0);
      check("arst_first_lane", 32'(status_first_err_lane), 32'hff);
      check("arst_state", 32'(status_state), 0);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
